// File: rtl/pipelined_add_sub_if.sv
// Operand/result handshake bundle for pipelined_add_sub.
// The sat signal exists only when ADDER_SAT_EN is defined.
interface pipelined_add_sub_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
`ifdef ADDER_SAT_EN
    logic             sat;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf, sat
    );
    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf, sat
    );
`else
    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );
    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
`endif
endinterface

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor: one CW-bit chunk per stage, carry ripples per clock.
// Define ADDER_SAT_EN to clamp overflowing results to the signed extremes and raise sat.
module pipelined_add_sub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input logic                clk,
    input logic                rst,
    pipelined_add_sub_if.slave bus
);
    localparam int CW = WIDTH / STAGES;
    localparam int PD = (STAGES > 1) ? STAGES - 1 : 1;
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_cfg_err
        $error("pipelined_add_sub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    // Inter-stage registers: full operands, partial result, chunk carry, beat valid.
    logic [PD-1:0][WIDTH-1:0]     a_q, b_q, r_q;
    logic [PD-1:0]                c_q, v_q;
    logic [STAGES-1:0][WIDTH-1:0] a_d, b_d, r_d;
    logic [STAGES-1:0]            c_d, v_d;

    logic             out_valid_q, c_out_q, ovf_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_d, ovf_d;
    logic [WIDTH-1:0] sum_d;
`ifdef ADDER_SAT_EN
    logic             sat_q, sat_d;
`endif

    logic             en_s, cin0_s, ic_s, iv_s, fa_s, fb_s;
    logic [WIDTH-1:0] b_eff_s, ia_s, ib_s, ir_s;
    logic [CW:0]      cs_s;
    int               pk_s;

    // Per-stage chunk adders plus final-stage overflow/saturation.
    always_comb begin
        en_s    = ~out_valid_q | bus.out_ready;
        b_eff_s = bus.sub ? ~bus.b : bus.b;
        cin0_s  = bus.sub ? 1'b1 : bus.c_in;
        a_d     = '0;
        b_d     = '0;
        r_d     = '0;
        c_d     = '0;
        v_d     = '0;
        ia_s    = '0;
        ib_s    = '0;
        ir_s    = '0;
        ic_s    = 1'b0;
        iv_s    = 1'b0;
        cs_s    = '0;
        pk_s    = 0;
        for (int k = 0; k < STAGES; k++) begin
            // Stage 0 is fed by the port; stage k by pipeline register k-1.
            pk_s = (k == 0) ? 0 : k - 1;
            ia_s = (k == 0) ? bus.a    : a_q[pk_s];
            ib_s = (k == 0) ? b_eff_s  : b_q[pk_s];
            ir_s = (k == 0) ? '0       : r_q[pk_s];
            ic_s = (k == 0) ? cin0_s   : c_q[pk_s];
            iv_s = (k == 0) ? bus.in_valid : v_q[pk_s];
            cs_s = {1'b0, ia_s[k*CW +: CW]} + {1'b0, ib_s[k*CW +: CW]} + {{CW{1'b0}}, ic_s};
            a_d[k] = ia_s;
            b_d[k] = ib_s;
            r_d[k] = ir_s;
            r_d[k][k*CW +: CW] = cs_s[CW-1:0];
            c_d[k] = cs_s[CW];
            v_d[k] = iv_s;
        end
        fa_s    = a_d[STAGES-1][WIDTH-1];
        fb_s    = b_d[STAGES-1][WIDTH-1];
        c_out_d = c_d[STAGES-1];
        ovf_d   = (fa_s == fb_s) & (r_d[STAGES-1][WIDTH-1] != fa_s);
`ifdef ADDER_SAT_EN
        sum_d   = ovf_d ? (fa_s ? SMIN : SMAX) : r_d[STAGES-1];
        sat_d   = ovf_d;
`else
        sum_d   = r_d[STAGES-1];
`endif
    end

    // Pipeline and output registers; a stall (en_s low) freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            v_q         <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef ADDER_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else if (en_s) begin
            a_q         <= a_d[PD-1:0];
            b_q         <= b_d[PD-1:0];
            r_q         <= r_d[PD-1:0];
            c_q         <= c_d[PD-1:0];
            v_q         <= v_d[PD-1:0];
            out_valid_q <= v_d[STAGES-1];
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            ovf_q       <= ovf_d;
`ifdef ADDER_SAT_EN
            sat_q       <= sat_d;
`endif
        end
    end

    assign bus.in_ready  = en_s;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;
`ifdef ADDER_SAT_EN
    assign bus.sat       = sat_q;
`endif
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed and random self-checking bench for pipelined_add_sub (WIDTH=64, STAGES=4).
// Honours ADDER_SAT_EN when defined.
module tb_pipelined_add_sub;
    localparam int W = 64;
    localparam int S = 4;
    localparam logic [W-1:0] SMAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [W-1:0] SMIN = 64'h8000_0000_0000_0000;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipelined_add_sub_if #(.WIDTH(W)) bus_if ();
    pipelined_add_sub #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst(rst), .bus(bus_if));

    task automatic chk64(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Whole-word reference: 65-bit add of a and the effective b.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         e;
        logic [W-1:0] be;
        logic [W:0]   t;
        be  = sub ? ~b : b;
        t   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        e.s = t[W-1:0];
        e.c = t[W];
        e.o = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
`ifdef ADDER_SAT_EN
        if (e.o) e.s = a[W-1] ? SMIN : SMAX;
`endif
        return e;
    endfunction

    task automatic send_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic cin, input logic sub, input logic [W-1:0] esum,
                              input logic ec, input logic eo);
        int           cnt;
        logic [W-1:0] exp_s;
        exp_s = esum;
`ifdef ADDER_SAT_EN
        if (eo) exp_s = a[W-1] ? SMIN : SMAX;
`endif
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.a        = a;
        bus_if.b        = b;
        bus_if.c_in     = cin;
        bus_if.sub      = sub;
        #1 chk1({tag, " in_ready"}, bus_if.in_ready, 1'b1);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        cnt = 1;
        while (!bus_if.out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk1({tag, " out_valid"}, bus_if.out_valid, 1'b1);
        chk64({tag, " latency"}, 64'(cnt), 64'(S));
        chk64({tag, " sum"}, bus_if.sum, exp_s);
        chk1({tag, " c_out"}, bus_if.c_out, ec);
        chk1({tag, " ovf"}, bus_if.ovf, eo);
`ifdef ADDER_SAT_EN
        chk1({tag, " sat"}, bus_if.sat, eo);
`endif
    endtask

    initial begin
        exp_t         q[$];
        exp_t         e;
        logic [W-1:0] ra, rb;
        logic         rc, rs;
        int           sent, got, cyc;

        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        bus_if.a         = '0;
        bus_if.b         = '0;
        bus_if.c_in      = 1'b0;
        bus_if.sub       = 1'b0;
        repeat (2) @(negedge clk);
        chk1("reset out_valid", bus_if.out_valid, 1'b0);
        chk64("reset sum", bus_if.sum, 64'h0);
        chk1("reset c_out", bus_if.c_out, 1'b0);
        chk1("reset ovf", bus_if.ovf, 1'b0);
        chk1("reset in_ready", bus_if.in_ready, 1'b1);
`ifdef ADDER_SAT_EN
        chk1("reset sat", bus_if.sat, 1'b0);
`endif
        rst = 1'b0;

        send_check("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                   64'h8000_0000_0000_0000, 1'b0, 1'b1);
        send_check("zero_minus_one", 64'h0, 64'h1, 1'b0, 1'b1,
                   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        send_check("five_minus_five", 64'h5, 64'h5, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0);
        send_check("chunk_carry", 64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
                   64'h0000_0001_0000_0000, 1'b0, 1'b0);
        send_check("neg_sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
                   64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        send_check("wrap_all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                   64'h0, 1'b1, 1'b0);
        send_check("sub_ignores_cin", 64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0);
        send_check("neg_add_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
                   64'h0, 1'b1, 1'b1);

        // Backpressure: result must hold and in_ready drop while out_ready is low.
        @(negedge clk);
        bus_if.out_ready = 1'b0;
        bus_if.in_valid  = 1'b1;
        bus_if.a         = 64'd3;
        bus_if.b         = 64'd4;
        bus_if.c_in      = 1'b0;
        bus_if.sub       = 1'b0;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk1("stall out_valid", bus_if.out_valid, 1'b1);
            chk64("stall sum", bus_if.sum, 64'd7);
            chk1("stall in_ready", bus_if.in_ready, 1'b0);
            @(negedge clk);
        end
        bus_if.out_ready = 1'b1;
        #1 chk1("unstall in_ready", bus_if.in_ready, 1'b1);
        @(negedge clk);
        chk1("unstall drained", bus_if.out_valid, 1'b0);

        // Reset with a full pipe: first result visible, three more in flight.
        for (int i = 0; i < 4; i++) begin
            bus_if.in_valid = 1'b1;
            bus_if.a        = 64'(i);
            bus_if.b        = 64'h1;
            @(negedge clk);
        end
        bus_if.in_valid = 1'b0;
        chk1("prerst out_valid", bus_if.out_valid, 1'b1);
        chk64("prerst sum", bus_if.sum, 64'h1);
        rst = 1'b1;
        #1;
        chk1("midrst out_valid", bus_if.out_valid, 1'b0);
        chk64("midrst sum", bus_if.sum, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("postrst discarded", bus_if.out_valid, 1'b0);
        end
        send_check("postrst beat", 64'h1234, 64'h0FFF, 1'b0, 1'b0, 64'h2233, 1'b0, 1'b0);

        // Random stream with random backpressure against the whole-word model.
        sent = 0;
        got  = 0;
        cyc  = 0;
        ra   = {$urandom, $urandom};
        rb   = {$urandom, $urandom};
        rc   = 1'($urandom_range(0, 1));
        rs   = 1'($urandom_range(0, 1));
        while ((sent < 16 || got < 16) && cyc < 600) begin
            @(negedge clk);
            cyc++;
            bus_if.out_ready = 1'($urandom_range(0, 1));
            bus_if.in_valid  = (sent < 16);
            bus_if.a         = ra;
            bus_if.b         = rb;
            bus_if.c_in      = rc;
            bus_if.sub       = rs;
            #1;
            if (bus_if.out_valid && bus_if.out_ready) begin
                chk1("rand expected beat", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk64("rand sum", bus_if.sum, e.s);
                    chk1("rand c_out", bus_if.c_out, e.c);
                    chk1("rand ovf", bus_if.ovf, e.o);
                end
                got++;
            end
            if (bus_if.in_valid && bus_if.in_ready) begin
                q.push_back(model(ra, rb, rc, rs));
                sent++;
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                rc = 1'($urandom_range(0, 1));
                rs = 1'($urandom_range(0, 1));
            end
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        chk64("rand received", 64'(got), 64'd16);
        chk64("rand leftover", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
